// File: rtl/bitwise_sweep_checker.sv
// ----------------------------------------------------------------------------
// bitwise_sweep_checker
//
// Purpose:
//   Clocked self-test stage for a WIDTH-bit bitwise-NOT unit. It walks every
//   input vector in ascending order onto dut_in. Each vector is held for SETTLE
//   cycles and then dut_out is checked for one cycle against the complement of
//   the applied vector. At the end of the sweep the block reports a
//   mismatch count, the first failing vector, and a pass flag.
//
// Ports:
//   clk            in   system clock, rising-edge
//   rst_n          in   asynchronous active-low reset
//   start          in   sweep request (see handshake note below)
//   dut_in         out  [WIDTH-1:0] vector driven to the unit (MSB = in1)
//   dut_out        in   [WIDTH-1:0] unit response (MSB = out1)
//   busy           out  sweep in progress (WAIT or CHECK)
//   done           out  sweep finished, results valid
//   pass           out  done and no mismatches
//   err_count      out  [WIDTH:0] mismatching vectors, saturates at 2^WIDTH
//   first_fail_vec out  [WIDTH-1:0] first mismatching vector in sweep order
//   fail_valid     out  first_fail_vec holds a captured vector
//
// Handshake: start is a level request with no ready. It is honoured on any
// rising edge where the FSM sits in IDLE or DONE. While busy it is ignored.
// A new sweep clears all results on the edge that accepts it.
//
// SETTLE must be in the range 1..15.
// ----------------------------------------------------------------------------
module bitwise_sweep_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic             fail_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] VEC_LAST    = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   ERR_MAX     = {1'b1, {WIDTH{1'b0}}};
  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [WIDTH-1:0] dut_in_q, dut_in_d;
  logic [3:0]       settle_q, settle_d;
  logic [WIDTH:0]   err_count_q, err_count_d;
  logic [WIDTH-1:0] first_fail_q, first_fail_d;
  logic             fail_valid_q, fail_valid_d;
  logic             vec_ok;

  // Every bit of a correct response differs from the applied vector.
  assign vec_ok = &(dut_out ^ dut_in_q);

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    dut_in_d     = dut_in_q;
    settle_d     = settle_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    fail_valid_d = fail_valid_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_WAIT;
          vec_d        = '0;
          dut_in_d     = '0;
          settle_d     = SETTLE_INIT;
          err_count_d  = '0;
          first_fail_d = '0;
          fail_valid_d = 1'b0;
        end
      end

      S_WAIT: begin
        settle_d = settle_q - 4'd1;
        if (settle_q <= 4'd1) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        // The mismatch path sits in the else branch on purpose. An unknown
        // vec_ok in simulation then takes it and is counted as a failure.
        if (vec_ok) begin
          err_count_d = err_count_q;
        end else begin
          if (err_count_q != ERR_MAX) begin
            err_count_d = err_count_q + 1'b1;
          end
          if (!fail_valid_q) begin
            first_fail_d = dut_in_q;
            fail_valid_d = 1'b1;
          end
        end

        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_WAIT;
          vec_d    = vec_q + 1'b1;
          dut_in_d = vec_q + 1'b1;
          settle_d = SETTLE_INIT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      dut_in_q     <= '0;
      settle_q     <= '0;
      err_count_q  <= '0;
      first_fail_q <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      dut_in_q     <= dut_in_d;
      settle_q     <= settle_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
      fail_valid_q <= fail_valid_d;
    end
  end

  assign dut_in         = dut_in_q;
  assign busy           = (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done           = (state_q == S_DONE);
  assign pass           = (state_q == S_DONE) && (err_count_q == '0);
  assign err_count      = err_count_q;
  assign first_fail_vec = first_fail_q;
  assign fail_valid     = fail_valid_q;

endmodule

// File: tb/tb_bitwise_sweep_checker.sv
// ----------------------------------------------------------------------------
// tb_bitwise_sweep_checker
//
// Purpose:
//   Self-checking bench for bitwise_sweep_checker. It instantiates two copies,
//   one with SETTLE=1 and one with SETTLE=3. Each copy is fed by a behavioural
//   NOT unit that can inject a selectable fault. Expected results for each
//   fault are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_bitwise_sweep_checker;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Stimulus controls.
  logic start1, start3;
  logic sel3;  // 0: SETTLE=1 instance, 1: SETTLE=3 instance
  int   mode;  // fault injected into the NOT model

  logic [3:0] dut_in1, dut_out1, dut_in3, dut_out3;
  logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
  logic [4:0] err1, err3;
  logic [3:0] ff1, ff3;

  // Behavioural NOT unit with selectable faults.
  // 0 correct, 1 identity, 2 bit0 stuck-0, 3 bit3 stuck-1, 4 forced 0 at 1010.
  function automatic logic [3:0] inv_model(input int m, input logic [3:0] x);
    logic [3:0] y;
    y = ~x;
    case (m)
      1: y = x;
      2: y[0] = 1'b0;
      3: y[3] = 1'b1;
      4: if (x == 4'b1010) y = 4'b0000;
      default: ;
    endcase
    return y;
  endfunction

  assign dut_out1 = inv_model(mode, dut_in1);
  assign dut_out3 = inv_model(mode, dut_in3);

  bitwise_sweep_checker #(.WIDTH(4), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .dut_in(dut_in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_vec(ff1), .fail_valid(fv1)
  );

  bitwise_sweep_checker #(.WIDTH(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .dut_in(dut_in3), .dut_out(dut_out3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail_vec(ff3), .fail_valid(fv3)
  );

  // Observation mux onto the selected instance.
  logic [3:0] dut_in_s, ff_s;
  logic [4:0] err_s;
  logic       busy_s, done_s, pass_s, fv_s;
  assign dut_in_s = sel3 ? dut_in3 : dut_in1;
  assign ff_s     = sel3 ? ff3     : ff1;
  assign err_s    = sel3 ? err3    : err1;
  assign busy_s   = sel3 ? busy3   : busy1;
  assign done_s   = sel3 ? done3   : done1;
  assign pass_s   = sel3 ? pass3   : pass1;
  assign fv_s     = sel3 ? fv3     : fv1;

  // Scoreboard counters.
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel3) start3 = v;
    else      start1 = v;
  endtask

  // Drive one start pulse. On return we are at the first negedge after
  // the accepting edge.
  task automatic pulse_start();
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
  endtask

  // Run a full sweep, measure busy length and the dut_in walk, then check
  // the results. repulse_at >= 0 re-pulses start at that busy cycle.
  task automatic run_sweep(input string tag, input int settle, input int exp_err,
                           input int exp_ff, input int exp_fv, input int repulse_at);
    int cycles;
    int walk_bad;
    cycles   = 0;
    walk_bad = 0;
    pulse_start();
    check({tag, "_clr_err"}, 32'(err_s), 32'd0);
    check({tag, "_clr_done"}, 32'(done_s), 32'd0);
    while (busy_s && cycles < 500) begin
      if (dut_in_s != 4'(cycles / (settle + 1))) walk_bad++;
      if (cycles == repulse_at) set_start(1'b1);
      else if (cycles == repulse_at + 1) set_start(1'b0);
      cycles++;
      @(negedge clk);
    end
    set_start(1'b0);
    check({tag, "_busy_cycles"}, 32'(cycles), 32'(16 * (settle + 1)));
    check({tag, "_walk"}, 32'(walk_bad), 32'd0);
    check({tag, "_done"}, 32'(done_s), 32'd1);
    check({tag, "_pass"}, 32'(pass_s), (exp_err == 0) ? 32'd1 : 32'd0);
    check({tag, "_err"}, 32'(err_s), 32'(exp_err));
    check({tag, "_ff"}, 32'(ff_s), 32'(exp_ff));
    check({tag, "_fv"}, 32'(fv_s), 32'(exp_fv));
    check({tag, "_last_vec"}, 32'(dut_in_s), 32'hF);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy_s), 32'd0);
    check({tag, "_done"}, 32'(done_s), 32'd0);
    check({tag, "_pass"}, 32'(pass_s), 32'd0);
    check({tag, "_err"}, 32'(err_s), 32'd0);
    check({tag, "_ff"}, 32'(ff_s), 32'd0);
    check({tag, "_fv"}, 32'(fv_s), 32'd0);
    check({tag, "_dut_in"}, 32'(dut_in_s), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    sel3   = 1'b0;
    mode   = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // SETTLE=1 sweeps, one per fault type.
    mode = 0; run_sweep("ok_s1", 1, 0, 0, 0, -1);
    mode = 1; run_sweep("ident", 1, 16, 4'b0000, 1, -1);
    mode = 2; run_sweep("b0_st0", 1, 8, 4'b0000, 1, -1);
    mode = 3; run_sweep("b3_st1", 1, 8, 4'b1000, 1, -1);
    mode = 4; run_sweep("f1010", 1, 1, 4'b1010, 1, -1);

    // A start pulse during the sweep must be ignored.
    mode = 0; run_sweep("repulse", 1, 0, 0, 0, 10);

    // Asynchronous reset mid-sweep, then a clean sweep.
    mode = 1;
    pulse_start();
    repeat (11) @(negedge clk);
    check("pre_rst_busy", 32'(busy_s), 32'd1);
    check("pre_rst_err_nz", 32'(err_s != 5'd0), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0; run_sweep("post_rst", 1, 0, 0, 0, -1);

    // SETTLE=3: a failing sweep, then a restart straight from DONE.
    sel3 = 1'b1;
    mode = 1; run_sweep("s3_fail", 3, 16, 4'b0000, 1, -1);
    mode = 0; run_sweep("s3_restart", 3, 0, 0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
